natalius_uart_tx: RTL and testbench
===================================

Name: natalius_uart_tx

Overview:
- Serial console output peripheral on the natalius processor I/O port bus, in the same port-address decode space as the col/row/color/dout registers.
- Consumes processor port writes (port_addr, write_e, data_out) into a byte FIFO and shifts bytes out as 8N1 UART frames on a single pin.
- Returns a status byte that the top level muxes onto the processor data_in path.

Parameters:
- CLK_DIV, 434, clock cycles per serial bit (>=2); 50 MHz / 115200.
- FIFO_DEPTH, 8, FIFO entries; power of two, >=2.
- ADDR_SEL, 3'b110, value of port_addr[7:5] that selects this block.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- port_addr  input  8  processor port address.
- write_e  input  1  processor port write strobe, one cycle per write.
- read_e  input  1  processor port read strobe; accepted, does not change state.
- data_out  input  8  processor write data.
- status  output  8  {4'b0, overflow, tx_active, full, empty}; combinational from registered state.
- tx  output  1  serial line, idle high, registered.
- busy  output  1  tx_active OR NOT empty.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - tx=1, state IDLE, FIFO empty (count 0), overflow=0, baud counter 0, bit index 0.
  - status=8'h01, busy=0.
- Decode: sel = (port_addr[7:5]==ADDR_SEL) AND write_e.
  - Data write: sel AND port_addr[0]==0.
  - Control write: sel AND port_addr[0]==1.
- Data write, push rule:
  - Pushes data_out when the FIFO is not full, or when the FIFO is full and a pop happens in the same cycle.
  - Otherwise the byte is dropped, FIFO is unchanged, and overflow is set to 1 (sticky).
- Control write: data_out[0]=1 clears overflow. Other bits are ignored. If a clear and a new overflow occur in the same cycle, set wins.
- FIFO: circular buffer. Read/write pointers wrap modulo FIFO_DEPTH. count 0..FIFO_DEPTH. empty=(count==0), full=(count==FIFO_DEPTH).
- Baud counter:
  - Loaded with CLK_DIV-1 on each bit start; decrements each cycle.
  - Bit ends when it is 0, so each bit lasts exactly CLK_DIV cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - tx=1.
    - If NOT empty: pop the head into the shift register, tx<=0, load the counter, go to START.
    - A byte pushed at edge N into an empty FIFO is popped at edge N+1; tx falls at edge N+1.
  - START, at bit end: tx<=shift[0] (LSB first), bit index 0, go to DATA.
  - DATA, at bit end:
    - If bit index<7: shift right, tx<=next bit, index+1.
    - Otherwise tx<=1 and go to STOP.
  - STOP, at bit end:
    - If NOT empty: pop, tx<=0, go to START. No idle gap between back-to-back frames.
    - Otherwise go to IDLE.
- tx_active=1 in START, DATA and STOP.
- Frame length: 10*CLK_DIV cycles.
- Writes arriving mid-frame only affect the FIFO. A frame in flight is never aborted except by reset.
- Reset mid-frame: tx returns to 1 immediately (asynchronous); queued bytes are discarded.
- read_e and reads of status have no side effects.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the 8 data bits) is sent after DATA bit 7, in an extra PARITY state lasting CLK_DIV cycles, before STOP.
  - Frame = 11*CLK_DIV cycles.
  - status[7]=1 to advertise the feature.
- Undefined: no PARITY state, 10-bit frame, status[7]=0.

Test Plan (CLK_DIV=4, FIFO_DEPTH=4, ADDR_SEL=3'b110):
- Reset: hold rst=0 with random inputs -> tx=1, status=8'h01, busy=0. Release -> stays idle.
- Single byte: write 8'hA5 at port 8'hC0 -> tx low 1 cycle after the write edge for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high. Back to IDLE after 40 cycles, status=8'h01.
- Back-to-back: write 8'h55 then 8'h0F on consecutive cycles -> second start bit immediately follows the first stop bit; total 80 cycles low-to-idle.
- Overflow: 6 writes in consecutive cycles -> first popped after 1 cycle, next 4 fill the FIFO, 6th dropped. status=8'h0E (overflow, tx_active, full).
- Overflow clear: write 8'h01 to port 8'hC1 -> overflow=0. Exactly 5 frames emitted in write order.
- Reset mid-frame: assert rst during DATA bit 3 -> tx=1 asynchronously. After release, no further frames and status=8'h01.
- UART_PARITY_EN defined: write 8'h07 -> parity bit 1 before stop; frame 44 cycles; status[7]=1.

Source files
------------

// File: rtl/natalius_uart_tx.sv
// Port-mapped 8N1 UART transmitter for the natalius I/O bus, with a byte FIFO and status readback.
// Build option: define UART_PARITY_EN to add an even-parity bit and advertise it in status[7].
module natalius_uart_tx #(
  parameter int         CLK_DIV    = 434,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [2:0] ADDR_SEL   = 3'b110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] port_addr,
  input  logic       write_e,
  input  logic       read_e,
  input  logic [7:0] data_out,
  output logic [7:0] status,
  output logic       tx,
  output logic       busy
);

  localparam int             BW         = $clog2(CLK_DIV);
  localparam int             PW         = $clog2(FIFO_DEPTH);
  localparam int             CW         = $clog2(FIFO_DEPTH + 1);
  localparam logic [BW-1:0]  BAUD_LOAD  = BW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  COUNT_FULL = CW'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
  localparam logic PAR_FLAG = 1'b1;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  localparam logic PAR_FLAG = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t          state_r, state_n;
  logic [7:0]      shift_r, shift_n;
  logic [2:0]      bit_idx_r, bit_idx_n;
  logic [BW-1:0]   baud_r, baud_n;
  logic            tx_r, tx_n;
  logic            overflow_r, overflow_n;
  logic [7:0]      mem_r [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r, count_n;
`ifdef UART_PARITY_EN
  logic            parity_r, parity_n;
`endif

  logic sel_s, data_wr_s, ctrl_wr_s, push_s, pop_s;
  logic empty_s, full_s, bit_end_s, tx_active_s;
  logic [7:0] head_s;
  logic unused_s;

  assign sel_s       = (port_addr[7:5] == ADDR_SEL) && write_e;
  assign data_wr_s   = sel_s && (port_addr[0] == 1'b0);
  assign ctrl_wr_s   = sel_s && (port_addr[0] == 1'b1);
  assign empty_s     = (count_r == {CW{1'b0}});
  assign full_s      = (count_r == COUNT_FULL);
  assign head_s      = mem_r[rd_ptr_r];
  assign bit_end_s   = (baud_r == {BW{1'b0}});
  assign tx_active_s = (state_r != IDLE);
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign push_s      = data_wr_s && (!full_s || pop_s);
  assign unused_s    = ^{read_e, port_addr[4:1], data_out[7:1]};

  assign status = {PAR_FLAG, 3'b000, overflow_r, tx_active_s, full_s, empty_s};
  assign tx     = tx_r;
  assign busy   = tx_active_s || !empty_s;

  // Serializer next-state, baud timing and FIFO pop request
  always_comb begin
    state_n   = state_r;
    shift_n   = shift_r;
    bit_idx_n = bit_idx_r;
    baud_n    = baud_r;
    tx_n      = tx_r;
    pop_s     = 1'b0;
`ifdef UART_PARITY_EN
    parity_n  = parity_r;
`endif
    case (state_r)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_n = head_s;
`ifdef UART_PARITY_EN
          parity_n = even_parity(head_s);
`endif
          tx_n    = 1'b0;
          baud_n  = BAUD_LOAD;
          state_n = START;
        end else begin
          baud_n = {BW{1'b0}};
        end
      end
      START: begin
        if (bit_end_s) begin
          tx_n      = shift_r[0];
          bit_idx_n = 3'd0;
          baud_n    = BAUD_LOAD;
          state_n   = DATA;
        end else begin
          baud_n = baud_r - BW'(1);
        end
      end
      DATA: begin
        if (bit_end_s) begin
          baud_n = BAUD_LOAD;
          if (bit_idx_r != 3'd7) begin
            shift_n   = {1'b0, shift_r[7:1]};
            tx_n      = shift_r[1];
            bit_idx_n = bit_idx_r + 3'd1;
          end else begin
`ifdef UART_PARITY_EN
            tx_n    = parity_r;
            state_n = PARITY;
`else
            tx_n    = 1'b1;
            state_n = STOP;
`endif
          end
        end else begin
          baud_n = baud_r - BW'(1);
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          tx_n    = 1'b1;
          baud_n  = BAUD_LOAD;
          state_n = STOP;
        end else begin
          baud_n = baud_r - BW'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end_s) begin
          if (!empty_s) begin
            pop_s   = 1'b1;
            shift_n = head_s;
`ifdef UART_PARITY_EN
            parity_n = even_parity(head_s);
`endif
            tx_n    = 1'b0;
            baud_n  = BAUD_LOAD;
            state_n = START;
          end else begin
            tx_n    = 1'b1;
            baud_n  = {BW{1'b0}};
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_r - BW'(1);
        end
      end
      default: begin
        tx_n    = 1'b1;
        baud_n  = {BW{1'b0}};
        state_n = IDLE;
      end
    endcase
  end

  // FIFO occupancy and sticky overflow; a new overflow beats a clear in the same cycle
  always_comb begin
    count_n    = count_r;
    overflow_n = overflow_r;
    case ({push_s, pop_s})
      2'b10:   count_n = count_r + CW'(1);
      2'b01:   count_n = count_r - CW'(1);
      default: count_n = count_r;
    endcase
    if (data_wr_s && !push_s) begin
      overflow_n = 1'b1;
    end else if (ctrl_wr_s && data_out[0]) begin
      overflow_n = 1'b0;
    end else begin
      overflow_n = overflow_r;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      shift_r    <= 8'h00;
      bit_idx_r  <= 3'd0;
      baud_r     <= {BW{1'b0}};
      tx_r       <= 1'b1;
      overflow_r <= 1'b0;
      count_r    <= {CW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
`ifdef UART_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      state_r    <= state_n;
      shift_r    <= shift_n;
      bit_idx_r  <= bit_idx_n;
      baud_r     <= baud_n;
      tx_r       <= tx_n;
      overflow_r <= overflow_n;
      count_r    <= count_n;
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
`ifdef UART_PARITY_EN
      parity_r   <= parity_n;
`endif
    end
  end

  // FIFO storage; contents are only meaningful below count_r
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data_out;
    end
  end

endmodule

// File: tb/tb_natalius_uart_tx.sv
// Directed bench for natalius_uart_tx with CLK_DIV=4, FIFO_DEPTH=4; drives and samples on the falling edge.
module tb_natalius_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] port_addr;
  logic       write_e;
  logic       read_e;
  logic [7:0] data_out;
  logic [7:0] status;
  logic       tx;
  logic       busy;

  int tests = 0;
  int fails = 0;

`ifdef UART_PARITY_EN
  localparam logic [7:0] ST_PAR = 8'h80;
  localparam int         NBITS  = 11;
`else
  localparam logic [7:0] ST_PAR = 8'h00;
  localparam int         NBITS  = 10;
`endif

  natalius_uart_tx #(
    .CLK_DIV   (4),
    .FIFO_DEPTH(4),
    .ADDR_SEL  (3'b110)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .port_addr(port_addr),
    .write_e  (write_e),
    .read_e   (read_e),
    .data_out (data_out),
    .status   (status),
    .tx       (tx),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Call at the falling edge just after tx dropped; returns one falling edge past the frame.
  task automatic check_frame(input logic [7:0] b, input string tag);
    logic [10:0] bits;
    bits      = 11'h7FF;
    bits[0]   = 1'b0;
    bits[8:1] = b;
`ifdef UART_PARITY_EN
    bits[9]   = ^b;
`endif
    for (int i = 0; i < NBITS; i++) begin
      for (int c = 0; c < 4; c++) begin
        chk(tag, {7'b0, tx}, {7'b0, bits[i]});
        @(negedge clk);
      end
    end
  endtask

  task automatic write_port(input logic [7:0] addr, input logic [7:0] d);
    @(negedge clk);
    port_addr = addr;
    data_out  = d;
    write_e   = 1'b1;
    @(negedge clk);
    write_e   = 1'b0;
  endtask

  logic [7:0] ob [6];

  initial begin
    ob = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    rst = 1'b0; port_addr = 8'h00; write_e = 1'b0; read_e = 1'b0; data_out = 8'h00;

    // Reset held with random bus activity
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      port_addr = 8'($urandom);
      data_out  = 8'($urandom);
      write_e   = 1'($urandom_range(0, 1));
      read_e    = 1'($urandom_range(0, 1));
    end
    chk("rst_tx", {7'b0, tx}, 8'h01);
    chk("rst_status", status, 8'h01 | ST_PAR);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    @(negedge clk);
    port_addr = 8'h00; write_e = 1'b0; read_e = 1'b0; data_out = 8'h00;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_tx", {7'b0, tx}, 8'h01);
    chk("post_rst_status", status, 8'h01 | ST_PAR);

    // Writes outside the decode window or a read strobe change nothing
    write_port(8'h40, 8'hAA);
    read_e = 1'b1;
    @(negedge clk);
    read_e = 1'b0;
    chk("other_addr_status", status, 8'h01 | ST_PAR);
    chk("other_addr_busy", {7'b0, busy}, 8'h00);

    // Single byte
    write_port(8'hC0, 8'hA5);
    chk("single_pre_tx", {7'b0, tx}, 8'h01);
    chk("single_pre_status", status, 8'h00 | ST_PAR);
    chk("single_pre_busy", {7'b0, busy}, 8'h01);
    @(negedge clk);
    check_frame(8'hA5, "single_frame");
    chk("single_end_status", status, 8'h01 | ST_PAR);
    chk("single_end_busy", {7'b0, busy}, 8'h00);
    chk("single_end_tx", {7'b0, tx}, 8'h01);

    // Back-to-back frames from consecutive writes
    @(negedge clk);
    port_addr = 8'hC0; data_out = 8'h55; write_e = 1'b1;
    @(negedge clk);
    data_out = 8'h0F;
    @(negedge clk);
    write_e = 1'b0;
    check_frame(8'h55, "b2b_frame0");
    check_frame(8'h0F, "b2b_frame1");
    chk("b2b_end_status", status, 8'h01 | ST_PAR);

    // Overflow with a concurrent overflow clear while frames drain
    @(negedge clk);
    fork
      begin
        port_addr = 8'hC0; data_out = ob[0]; write_e = 1'b1;
        for (int k = 1; k < 6; k++) begin
          @(negedge clk);
          data_out = ob[k];
        end
        @(negedge clk);
        write_e = 1'b0;
        chk("ovf_status", status, 8'h0E | ST_PAR);
        chk("ovf_busy", {7'b0, busy}, 8'h01);
        @(negedge clk);
        port_addr = 8'hC1; data_out = 8'h01; write_e = 1'b1;
        @(negedge clk);
        write_e = 1'b0; port_addr = 8'hC0;
        chk("ovf_clear_status", status, 8'h06 | ST_PAR);
      end
      begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
          check_frame(ob[k], "ovf_frame");
        end
      end
    join
    chk("ovf_end_status", status, 8'h01 | ST_PAR);
    for (int i = 0; i < 5; i++) begin
      repeat (8) @(negedge clk);
      chk("ovf_no_sixth", {7'b0, tx}, 8'h01);
    end

    // Reset during DATA bit 3 with a second byte queued
    write_port(8'hC0, 8'hB4);
    write_port(8'hC0, 8'h3C);
    repeat (17) @(negedge clk);
    chk("mid_bit3_tx", {7'b0, tx}, 8'h00);
    chk("mid_bit3_busy", {7'b0, busy}, 8'h01);
    rst = 1'b0;
    #1;
    chk("async_rst_tx", {7'b0, tx}, 8'h01);
    chk("async_rst_status", status, 8'h01 | ST_PAR);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      repeat (10) @(negedge clk);
      chk("after_rst_idle_tx", {7'b0, tx}, 8'h01);
    end
    chk("after_rst_status", status, 8'h01 | ST_PAR);
    chk("after_rst_busy", {7'b0, busy}, 8'h00);

    // Odd-weight byte exercises the parity bit when enabled
    write_port(8'hC0, 8'h07);
    @(negedge clk);
    check_frame(8'h07, "par_frame");
    chk("par_end_status", status, 8'h01 | ST_PAR);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
